// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_ctrl
// Description : Stall/flush sequencer for the 5-stage RISC-V pipeline. Turns
//               memory busy-waits, load-use hazards and taken branches into
//               PC / pipeline-register write enables and bubble controls.
//               Also keeps stall and redirect statistics and flags busy-waits
//               that never end.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 1,    // IF/ID flush cycles per redirect (1..3)
  parameter int TIMEOUT      = 255,  // freeze length that raises BUSY_TIMEOUT
  parameter int CNT_W        = 16    // statistics counter width
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             IMEM_BUSY,
  input  logic             DMEM_BUSY,
  input  logic [4:0]       ID_RS1,
  input  logic [4:0]       ID_RS2,
  input  logic             ID_USES_RS1,
  input  logic             ID_USES_RS2,
  input  logic [4:0]       EX_RD,
  input  logic             EX_MEM_READ,
  input  logic             BRANCH_TAKEN,
  output logic             PC_WRITE_EN,
  output logic             IFID_WRITE_EN,
  output logic             IDEX_WRITE_EN,
  output logic             EXMEM_WRITE_EN,
  output logic             MEMWB_WRITE_EN,
  output logic             IFID_FLUSH,
  output logic             IDEX_FLUSH,
  output logic [1:0]       STATE,
  output logic             BUSY_TIMEOUT,
  output logic [CNT_W-1:0] STALL_COUNT,
  output logic [CNT_W-1:0] REDIRECT_COUNT
);

  localparam int                BUSY_W       = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [BUSY_W-1:0] BUSY_MAX     = BUSY_W'(TIMEOUT);
  localparam logic [BUSY_W-1:0] BUSY_ONE     = BUSY_W'(1);
  localparam logic [1:0]        FLUSH_RELOAD = 2'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX      = '1;

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    FREEZE = 2'b01,
    FLUSH  = 2'b10
  } state_t;

  state_t             state, state_nxt;
  state_t             resume, resume_nxt;
  state_t             eval_state;
  logic [1:0]         flush_cnt, flush_cnt_nxt;
  logic [BUSY_W-1:0]  busy_cnt, busy_cnt_nxt;
  logic               freeze;
  logic               load_use;
  logic               stall_inc;
  logic               redirect_inc;
  logic               timeout_hit;
  logic               timeout_flag;
  logic [CNT_W-1:0]   stall_count;
  logic [CNT_W-1:0]   redirect_count;

  assign freeze   = IMEM_BUSY | DMEM_BUSY;
  assign load_use = EX_MEM_READ & (EX_RD != 5'd0) &
                    ((ID_USES_RS1 & (ID_RS1 == EX_RD)) |
                     (ID_USES_RS2 & (ID_RS2 == EX_RD)));

  // On the cycle a freeze ends, the pipeline behaves as the state it froze in.
  assign eval_state = (state == FREEZE) ? resume : state;

  // Next-state and control outputs, priority freeze > branch > load-use.
  always_comb begin
    PC_WRITE_EN    = 1'b1;
    IFID_WRITE_EN  = 1'b1;
    IDEX_WRITE_EN  = 1'b1;
    EXMEM_WRITE_EN = 1'b1;
    MEMWB_WRITE_EN = 1'b1;
    IFID_FLUSH     = 1'b0;
    IDEX_FLUSH     = 1'b0;
    state_nxt      = state;
    resume_nxt     = resume;
    flush_cnt_nxt  = flush_cnt;
    busy_cnt_nxt   = busy_cnt;
    stall_inc      = 1'b0;
    redirect_inc   = 1'b0;
    timeout_hit    = 1'b0;

    if (!RESET) begin
      // Hold the PC and fill every register with bubbles.
      PC_WRITE_EN = 1'b0;
      IFID_FLUSH  = 1'b1;
      IDEX_FLUSH  = 1'b1;
    end else if (freeze) begin
      PC_WRITE_EN    = 1'b0;
      IFID_WRITE_EN  = 1'b0;
      IDEX_WRITE_EN  = 1'b0;
      EXMEM_WRITE_EN = 1'b0;
      MEMWB_WRITE_EN = 1'b0;
      stall_inc      = 1'b1;
      if (state != FREEZE) begin
        state_nxt    = FREEZE;
        resume_nxt   = state;
        busy_cnt_nxt = BUSY_ONE;
      end else if (busy_cnt != BUSY_MAX) begin
        busy_cnt_nxt = busy_cnt + BUSY_ONE;
      end
      timeout_hit = (busy_cnt_nxt == BUSY_MAX);
    end else begin
      busy_cnt_nxt = '0;
      state_nxt    = eval_state;
      case (eval_state)
        FLUSH: begin
          // ID contents are discarded here, so load-use is irrelevant.
          IFID_FLUSH = 1'b1;
          IDEX_FLUSH = 1'b1;
          if (BRANCH_TAKEN) begin
            redirect_inc  = 1'b1;
            flush_cnt_nxt = FLUSH_RELOAD;
          end else if (flush_cnt <= 2'd1) begin
            state_nxt = RUN;
          end else begin
            flush_cnt_nxt = flush_cnt - 2'd1;
          end
        end
        default: begin
          if (BRANCH_TAKEN) begin
            IFID_FLUSH   = 1'b1;
            IDEX_FLUSH   = 1'b1;
            redirect_inc = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              state_nxt     = FLUSH;
              flush_cnt_nxt = FLUSH_RELOAD;
            end else begin
              state_nxt = RUN;
            end
          end else if (load_use) begin
            // Hold PC and IF/ID one cycle, inject a bubble into ID/EX.
            PC_WRITE_EN   = 1'b0;
            IFID_WRITE_EN = 1'b0;
            IDEX_FLUSH    = 1'b1;
            stall_inc     = 1'b1;
            state_nxt     = RUN;
          end else begin
            state_nxt = RUN;
          end
        end
      endcase
    end
  end

  // Sequencer state register.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state     <= RUN;
      resume    <= RUN;
      flush_cnt <= 2'd0;
      busy_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      resume    <= resume_nxt;
      flush_cnt <= flush_cnt_nxt;
      busy_cnt  <= busy_cnt_nxt;
    end
  end

  // Saturating statistics counters and sticky busy-timeout flag.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      stall_count    <= '0;
      redirect_count <= '0;
      timeout_flag   <= 1'b0;
    end else begin
      if (stall_inc && (stall_count != CNT_MAX)) begin
        stall_count <= stall_count + CNT_ONE;
      end
      if (redirect_inc && (redirect_count != CNT_MAX)) begin
        redirect_count <= redirect_count + CNT_ONE;
      end
      if (timeout_hit) begin
        timeout_flag <= 1'b1;
      end
    end
  end

  assign STATE          = state;
  assign BUSY_TIMEOUT   = timeout_flag;
  assign STALL_COUNT    = stall_count;
  assign REDIRECT_COUNT = redirect_count;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_hazard_ctrl
// Description : Self-checking bench for pipeline_hazard_ctrl. Two instances
//               with different parameters share one stimulus stream and are
//               compared each cycle against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

  logic       clk;
  logic       reset;
  logic       imem_busy, dmem_busy;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_uses_rs1, id_uses_rs2, ex_mem_read, branch_taken;

  logic        a_pc, a_ifid, a_idex, a_exmem, a_memwb, a_ifid_fl, a_idex_fl, a_to;
  logic [1:0]  a_state;
  logic [15:0] a_stall, a_redir;
  logic        b_pc, b_ifid, b_idex, b_exmem, b_memwb, b_ifid_fl, b_idex_fl, b_to;
  logic [1:0]  b_state;
  logic [1:0]  b_stall, b_redir;

  logic [41:0] act_a, exp_a;
  logic [13:0] act_b, exp_b;
  logic [6:0]  ctl_a;

  int n_cmp  = 0;
  int n_fail = 0;

  // Model view of the sequencer: mode 0 run, 1 frozen, 2 flushing.
  typedef struct {
    int mode;
    int resume;
    int fcnt;
    int bcnt;
    bit to;
    int stall;
    int redir;
  } mst_t;

  mst_t ma, mb, na, nb;

  // Instance A: two-cycle redirect flush, short timeout, wide counters.
  pipeline_hazard_ctrl #(.FLUSH_CYCLES(2), .TIMEOUT(8), .CNT_W(16)) u_dut_a (
    .CLK(clk), .RESET(reset), .IMEM_BUSY(imem_busy), .DMEM_BUSY(dmem_busy),
    .ID_RS1(id_rs1), .ID_RS2(id_rs2), .ID_USES_RS1(id_uses_rs1), .ID_USES_RS2(id_uses_rs2),
    .EX_RD(ex_rd), .EX_MEM_READ(ex_mem_read), .BRANCH_TAKEN(branch_taken),
    .PC_WRITE_EN(a_pc), .IFID_WRITE_EN(a_ifid), .IDEX_WRITE_EN(a_idex),
    .EXMEM_WRITE_EN(a_exmem), .MEMWB_WRITE_EN(a_memwb), .IFID_FLUSH(a_ifid_fl),
    .IDEX_FLUSH(a_idex_fl), .STATE(a_state), .BUSY_TIMEOUT(a_to),
    .STALL_COUNT(a_stall), .REDIRECT_COUNT(a_redir));

  // Instance B: three-cycle flush, tiny timeout, 2-bit saturating counters.
  pipeline_hazard_ctrl #(.FLUSH_CYCLES(3), .TIMEOUT(4), .CNT_W(2)) u_dut_b (
    .CLK(clk), .RESET(reset), .IMEM_BUSY(imem_busy), .DMEM_BUSY(dmem_busy),
    .ID_RS1(id_rs1), .ID_RS2(id_rs2), .ID_USES_RS1(id_uses_rs1), .ID_USES_RS2(id_uses_rs2),
    .EX_RD(ex_rd), .EX_MEM_READ(ex_mem_read), .BRANCH_TAKEN(branch_taken),
    .PC_WRITE_EN(b_pc), .IFID_WRITE_EN(b_ifid), .IDEX_WRITE_EN(b_idex),
    .EXMEM_WRITE_EN(b_exmem), .MEMWB_WRITE_EN(b_memwb), .IFID_FLUSH(b_ifid_fl),
    .IDEX_FLUSH(b_idex_fl), .STATE(b_state), .BUSY_TIMEOUT(b_to),
    .STALL_COUNT(b_stall), .REDIRECT_COUNT(b_redir));

  assign ctl_a = {a_pc, a_ifid, a_idex, a_exmem, a_memwb, a_ifid_fl, a_idex_fl};
  assign act_a = {ctl_a, a_state, a_to, a_stall, a_redir};
  assign act_b = {b_pc, b_ifid, b_idex, b_exmem, b_memwb, b_ifid_fl, b_idex_fl,
                  b_state, b_to, b_stall, b_redir};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural rules: control bits {pc, ifid, idex, exmem, memwb, ifid_fl, idex_fl}.
  task automatic model(input mst_t s, input int fc, input int tmo, input int cw,
                       output logic [6:0] ctl, output mst_t ns);
    int  maxc;
    int  eff;
    bit  frz;
    bit  lu;
    maxc = (1 << cw) - 1;
    frz  = imem_busy || dmem_busy;
    lu   = ex_mem_read && (ex_rd != 0) &&
           ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
    ns   = s;
    if (!reset) begin
      ctl = 7'b0111111;
      ns  = '{default: 0};
    end else if (frz) begin
      ctl      = 7'b0000000;
      ns.stall = (s.stall < maxc) ? s.stall + 1 : maxc;
      if (s.mode != 1) begin
        ns.mode   = 1;
        ns.resume = s.mode;
        ns.bcnt   = 1;
      end else begin
        ns.bcnt = (s.bcnt < tmo) ? s.bcnt + 1 : tmo;
      end
      if (ns.bcnt >= tmo) ns.to = 1'b1;
    end else begin
      eff     = (s.mode == 1) ? s.resume : s.mode;
      ns.bcnt = 0;
      ns.mode = eff;
      if (eff == 2) begin
        ctl = 7'b1111111;
        if (branch_taken) begin
          ns.redir = (s.redir < maxc) ? s.redir + 1 : maxc;
          ns.fcnt  = fc - 1;
        end else if (s.fcnt <= 1) begin
          ns.mode = 0;
        end else begin
          ns.fcnt = s.fcnt - 1;
        end
      end else if (branch_taken) begin
        ctl      = 7'b1111111;
        ns.redir = (s.redir < maxc) ? s.redir + 1 : maxc;
        if (fc > 1) begin
          ns.mode = 2;
          ns.fcnt = fc - 1;
        end
      end else if (lu) begin
        ctl      = 7'b0011101;
        ns.stall = (s.stall < maxc) ? s.stall + 1 : maxc;
      end else begin
        ctl = 7'b1111100;
      end
    end
  endtask

  task automatic eval_models();
    logic [6:0] ca, cb;
    model(ma, 2, 8, 16, ca, na);
    model(mb, 3, 4, 2, cb, nb);
    exp_a = {ca, 2'(ma.mode), ma.to, 16'(ma.stall), 16'(ma.redir)};
    exp_b = {cb, 2'(mb.mode), mb.to, 2'(mb.stall), 2'(mb.redir)};
  endtask

  // Commit the model at the active edge, return at the falling edge.
  task automatic advance();
    @(posedge clk);
    ma = na;
    mb = nb;
    @(negedge clk);
  endtask

  task automatic set_idle();
    reset = 1'b1; imem_busy = 1'b0; dmem_busy = 1'b0; branch_taken = 1'b0;
    ex_mem_read = 1'b0; ex_rd = 5'd0; id_rs1 = 5'd0; id_rs2 = 5'd0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
  endtask

  task automatic do_reset();
    set_idle();
    reset = 1'b0;
    #1;
    eval_models();
    advance();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    set_idle();
    reset = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      eval_models();
      n_cmp++;
      if (ctl_a !== 7'b0111111) begin
        n_fail++;
        $display("FAIL reset_ctl cycle %0d: got %b want 0111111", c, ctl_a);
      end
      if (c == 1) begin
        n_cmp++;
        if (act_b !== exp_b) begin
          n_fail++;
          $display("FAIL reset_b: got %h want %h", act_b, exp_b);
        end
      end
      advance();
    end
    reset = 1'b1;
    #1;
    eval_models();
    n_cmp++;
    if (act_a !== {7'b1111100, 2'b00, 1'b0, 16'd0, 16'd0}) begin
      n_fail++;
      $display("FAIL reset_release_a: got %h want run/idle/zero", act_a);
    end
    n_cmp++;
    if (act_b !== exp_b) begin
      n_fail++;
      $display("FAIL reset_release_b: got %h want %h", act_b, exp_b);
    end
    advance();
  endtask

  task automatic test_load_use();
    do_reset();
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_uses_rs2 = 1'b1; id_rs1 = 5'd7;
    #1;
    eval_models();
    n_cmp++;
    if (ctl_a !== 7'b0011101) begin
      n_fail++;
      $display("FAIL load_use_ctl: got %b want 0011101", ctl_a);
    end
    advance();
    set_idle();
    #1;
    eval_models();
    n_cmp++;
    if (a_stall !== 16'd1 || ctl_a !== 7'b1111100) begin
      n_fail++;
      $display("FAIL load_use_after: got stall %0d ctl %b want 1 / 1111100", a_stall, ctl_a);
    end
    advance();
    ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs2 = 5'd0; id_uses_rs2 = 1'b1;
    #1;
    eval_models();
    n_cmp++;
    if (ctl_a !== 7'b1111100) begin
      n_fail++;
      $display("FAIL load_use_x0: got %b want 1111100", ctl_a);
    end
    n_cmp++;
    if (act_b !== exp_b) begin
      n_fail++;
      $display("FAIL load_use_x0_b: got %h want %h", act_b, exp_b);
    end
    advance();
  endtask

  task automatic test_branch();
    logic [1:0] want_st [4];
    logic       want_fl [4];
    want_st = '{2'b00, 2'b10, 2'b00, 2'b00};
    want_fl = '{1'b1, 1'b1, 1'b0, 1'b0};
    do_reset();
    for (int c = 0; c < 4; c++) begin
      set_idle();
      branch_taken = (c == 0);
      #1;
      eval_models();
      n_cmp++;
      if (a_state !== want_st[c] || a_ifid_fl !== want_fl[c]) begin
        n_fail++;
        $display("FAIL branch_seq cycle %0d: got st %b fl %b want st %b fl %b",
                 c, a_state, a_ifid_fl, want_st[c], want_fl[c]);
      end
      n_cmp++;
      if (act_b !== exp_b) begin
        n_fail++;
        $display("FAIL branch_b cycle %0d: got %h want %h", c, act_b, exp_b);
      end
      advance();
    end
    #1;
    n_cmp++;
    if (a_redir !== 16'd1) begin
      n_fail++;
      $display("FAIL branch_count: got %0d want 1", a_redir);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    // Freeze with a branch waiting: the release cycle performs the redirect.
    for (int c = 0; c < 6; c++) begin
      set_idle();
      dmem_busy    = (c < 4);
      branch_taken = (c < 5);
      #1;
      eval_models();
      n_cmp++;
      if (c < 4 && ctl_a !== 7'b0000000) begin
        n_fail++;
        $display("FAIL freeze_ctl cycle %0d: got %b want 0000000", c, ctl_a);
      end else if (c == 4 && (ctl_a !== 7'b1111111 || a_stall !== 16'd4)) begin
        n_fail++;
        $display("FAIL freeze_release: got ctl %b stall %0d want 1111111 / 4", ctl_a, a_stall);
      end else if (c == 5 && act_a !== exp_a) begin
        n_fail++;
        $display("FAIL freeze_after: got %h want %h", act_a, exp_a);
      end
      n_cmp++;
      if (act_b !== exp_b) begin
        n_fail++;
        $display("FAIL freeze_b cycle %0d: got %h want %h", c, act_b, exp_b);
      end
      advance();
    end
    #1;
    n_cmp++;
    if (a_redir !== 16'd1) begin
      n_fail++;
      $display("FAIL freeze_redirects: got %0d want 1", a_redir);
    end
  endtask

  task automatic test_freeze_in_flush();
    do_reset();
    for (int c = 0; c < 6; c++) begin
      set_idle();
      branch_taken = (c == 0);
      imem_busy    = (c >= 1 && c <= 3);
      #1;
      eval_models();
      n_cmp++;
      if (c == 4 && (a_ifid_fl !== 1'b1 || a_pc !== 1'b1)) begin
        n_fail++;
        $display("FAIL flush_resume: got fl %b pc %b want 1 / 1", a_ifid_fl, a_pc);
      end else if (c == 5 && (a_state !== 2'b00 || a_ifid_fl !== 1'b0)) begin
        n_fail++;
        $display("FAIL flush_done: got st %b fl %b want 00 / 0", a_state, a_ifid_fl);
      end else if (act_a !== exp_a) begin
        n_fail++;
        $display("FAIL flush_freeze_a cycle %0d: got %h want %h", c, act_a, exp_a);
      end
      n_cmp++;
      if (act_b !== exp_b) begin
        n_fail++;
        $display("FAIL flush_freeze_b cycle %0d: got %h want %h", c, act_b, exp_b);
      end
      advance();
    end
  endtask

  task automatic test_timeout();
    do_reset();
    for (int c = 0; c < 12; c++) begin
      set_idle();
      imem_busy = (c < 10);
      #1;
      eval_models();
      n_cmp++;
      if (a_to !== (c >= 8)) begin
        n_fail++;
        $display("FAIL timeout_a cycle %0d: got %b want %b", c, a_to, (c >= 8));
      end
      if (c == 5) begin
        n_cmp++;
        if (b_stall !== 2'd3) begin
          n_fail++;
          $display("FAIL stall_saturate: got %0d want 3", b_stall);
        end
      end
      n_cmp++;
      if (act_b !== exp_b) begin
        n_fail++;
        $display("FAIL timeout_b cycle %0d: got %h want %h", c, act_b, exp_b);
      end
      advance();
    end
    do_reset();
    #1;
    n_cmp++;
    if (a_to !== 1'b0 || b_to !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_clear: got %b %b want 0 0", a_to, b_to);
    end
  endtask

  task automatic test_random();
    int burst = 0;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if (burst == 0 && $urandom_range(40) == 0) burst = $urandom_range(12, 3);
      reset        = ($urandom_range(79) != 0);
      imem_busy    = (burst > 0) || ($urandom_range(11) == 0);
      dmem_busy    = ($urandom_range(11) == 0);
      branch_taken = ($urandom_range(5) == 0);
      ex_mem_read  = ($urandom_range(1) == 1);
      ex_rd        = 5'($urandom_range(3));
      id_rs1       = 5'($urandom_range(3));
      id_rs2       = 5'($urandom_range(3));
      id_uses_rs1  = ($urandom_range(1) == 1);
      id_uses_rs2  = ($urandom_range(1) == 1);
      if (burst > 0) burst--;
      #1;
      eval_models();
      n_cmp++;
      if (act_a !== exp_a) begin
        n_fail++;
        $display("FAIL random_a cycle %0d: got %h want %h", c, act_a, exp_a);
      end
      n_cmp++;
      if (act_b !== exp_b) begin
        n_fail++;
        $display("FAIL random_b cycle %0d: got %h want %h", c, act_b, exp_b);
      end
      advance();
    end
  endtask

  initial begin
    ma = '{default: 0};
    mb = '{default: 0};
    set_idle();
    test_reset();
    test_load_use();
    test_branch();
    test_back_to_back();
    test_freeze_in_flush();
    test_timeout();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
